// File: rtl/ball_engine.sv
// -----------------------------------------------------------------------------
// ball_engine
//
// Ball physics stage that sits directly upstream of the game-state controller.
// Once per frame tick the ball advances by (speed, 1) pixels, reflects off the
// top/bottom walls and both paddles, and reports a miss on ballStatus. While
// the controller is not in PLAY, the ball is parked at the screen centre and
// its launch direction follows the serving player.
//
// Optional feature (compile-time macro BALL_SPEEDUP_EN):
//   defined   - each paddle hit raises the horizontal speed by one pixel/tick,
//               saturating at SPEED_MAX; parking restores SPEED_INIT.
//   undefined - horizontal speed is the constant SPEED_INIT.
//
// Ports:
//   clk        in   1   system clock
//   rst        in   1   asynchronous reset, active low
//   state      in   2   game state: 00 START, 01 SERVE, 10 PLAY, 11 DONE
//   serve      in   1   0 = player 1 serves (+x), 1 = player 2 serves (-x)
//   paddle1_y  in  10   top y of the left paddle
//   paddle2_y  in  10   top y of the right paddle
//   ball_x     out 10   ball top-left x
//   ball_y     out 10   ball top-left y
//   ballStatus out  2   00 PLAYING, 01 PLAYER1WIN, 10 PLAYER2WIN
// -----------------------------------------------------------------------------
module ball_engine #(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int BALL_SIZE  = 8,
    parameter int PADDLE_W   = 8,
    parameter int PADDLE_H   = 64,
    parameter int P1_X       = 16,
    parameter int P2_X       = 616,
    parameter int TICK_DIV   = 833333,
    parameter int SPEED_INIT = 2,
    parameter int SPEED_MAX  = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] state,
    input  logic       serve,
    input  logic [9:0] paddle1_y,
    input  logic [9:0] paddle2_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [1:0] ballStatus
);

    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_SERVE = 2'b01,
        ST_PLAY  = 2'b10,
        ST_DONE  = 2'b11
    } game_state_t;

    typedef enum logic [1:0] {
        BS_PLAYING = 2'b00,
        BS_P1WIN   = 2'b01,
        BS_P2WIN   = 2'b10
    } ball_status_t;

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SPD_W = $clog2(SPEED_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    // Geometry in the 12-bit signed domain used for the next-position maths,
    // so that a step past the left/top edge shows up as a value <= 0.
    localparam logic signed [11:0] X0        = 12'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic signed [11:0] Y0        = 12'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic signed [11:0] X_MAX     = 12'(SCREEN_W - BALL_SIZE);
    localparam logic signed [11:0] Y_MAX     = 12'(SCREEN_H - BALL_SIZE);
    localparam logic signed [11:0] BALL      = 12'(BALL_SIZE);
    localparam logic signed [11:0] PAD_H     = 12'(PADDLE_H);
    localparam logic signed [11:0] P1_LEFT   = 12'(P1_X);
    localparam logic signed [11:0] P1_RIGHT  = 12'(P1_X + PADDLE_W - 1);
    localparam logic signed [11:0] P1_BOUNCE = 12'(P1_X + PADDLE_W);
    localparam logic signed [11:0] P2_LEFT   = 12'(P2_X);
    localparam logic signed [11:0] P2_RIGHT  = 12'(P2_X + PADDLE_W - 1);
    localparam logic signed [11:0] P2_BOUNCE = 12'(P2_X - BALL_SIZE);

    game_state_t       game_state;
    logic [CNT_W-1:0]  tick_cnt;
    logic              tick;

    logic [9:0]        x_q, x_d;
    logic [9:0]        y_q, y_d;
    logic              dx_q, dx_d;   // 1 = moving +x
    logic              dy_q, dy_d;   // 1 = moving +y (down)
    ball_status_t      status_q, status_d;
    logic [SPD_W-1:0]  speed;

    logic signed [11:0] cur_x, cur_y, step_x, nx, ny, pad1, pad2;
    logic               hit_left, hit_right;

    assign game_state = game_state_t'(state);

    // -------------------------------------------------------------------------
    // Frame tick: free-running in every game state.
    // -------------------------------------------------------------------------
    assign tick = (tick_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Horizontal speed
    // -------------------------------------------------------------------------
`ifdef BALL_SPEEDUP_EN
    logic [SPD_W-1:0] speed_q, speed_d, speed_bump;

    assign speed      = speed_q;
    assign speed_bump = (speed_q >= SPD_W'(SPEED_MAX)) ? speed_q : speed_q + SPD_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            speed_q <= SPD_W'(SPEED_INIT);
        end else begin
            speed_q <= speed_d;
        end
    end
`else
    assign speed = SPD_W'(SPEED_INIT);
`endif

    // -------------------------------------------------------------------------
    // Candidate position and collision tests
    // -------------------------------------------------------------------------
    assign cur_x  = $signed({2'b00, x_q});
    assign cur_y  = $signed({2'b00, y_q});
    assign step_x = $signed(12'(speed));
    assign pad1   = $signed({2'b00, paddle1_y});
    assign pad2   = $signed({2'b00, paddle2_y});

    assign nx = dx_q ? (cur_x + step_x) : (cur_x - step_x);
    assign ny = dy_q ? (cur_y + 12'sd1) : (cur_y - 12'sd1);

    // Paddle overlap is judged against the current (pre-move) y.
    assign hit_left  = !dx_q
                       && (nx <= P1_RIGHT) && (nx + BALL > P1_LEFT)
                       && (cur_y + BALL > pad1) && (cur_y < pad1 + PAD_H);
    assign hit_right = dx_q
                       && (nx <= P2_RIGHT) && (nx + BALL > P2_LEFT)
                       && (cur_y + BALL > pad2) && (cur_y < pad2 + PAD_H);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every next-state variable starts at its hold value so that no
        // branch leaves it unassigned; otherwise synthesis infers latches.
        x_d      = x_q;
        y_d      = y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        status_d = status_q;
`ifdef BALL_SPEEDUP_EN
        speed_d  = speed_q;
`endif

        if (game_state != ST_PLAY) begin
            // Parked at centre, aimed at the receiving player.
            x_d      = X0[9:0];
            y_d      = Y0[9:0];
            dx_d     = ~serve;
            dy_d     = 1'b1;
            status_d = BS_PLAYING;
`ifdef BALL_SPEEDUP_EN
            speed_d  = SPD_W'(SPEED_INIT);
`endif
        end else if (status_q == BS_PLAYING && tick) begin
            // Walls act independently of the horizontal outcome.
            if (ny <= 12'sd0) begin
                y_d  = '0;
                dy_d = 1'b1;
            end else if (ny >= Y_MAX) begin
                y_d  = Y_MAX[9:0];
                dy_d = 1'b0;
            end else begin
                y_d  = ny[9:0];
            end

            // Paddle hit beats miss beats free motion.
            if (hit_left) begin
                x_d  = P1_BOUNCE[9:0];
                dx_d = 1'b1;
`ifdef BALL_SPEEDUP_EN
                speed_d = speed_bump;
`endif
            end else if (hit_right) begin
                x_d  = P2_BOUNCE[9:0];
                dx_d = 1'b0;
`ifdef BALL_SPEEDUP_EN
                speed_d = speed_bump;
`endif
            end else if (nx <= 12'sd0) begin
                x_d      = '0;
                status_d = BS_P2WIN;
            end else if (nx >= X_MAX) begin
                x_d      = X_MAX[9:0];
                status_d = BS_P1WIN;
            end else begin
                x_d = nx[9:0];
            end
        end
        // A latched miss freezes the ball until the controller leaves PLAY,
        // so it sees exactly one scoring event.
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: every register has a reset value; the controller reads
        // ballStatus straight out of reset and must never see X.
        if (!rst) begin
            x_q      <= X0[9:0];
            y_q      <= Y0[9:0];
            dx_q     <= 1'b1;
            dy_q     <= 1'b1;
            status_q <= BS_PLAYING;
        end else begin
            // NOTE: non-blocking assignments so all registers update together
            // from the same pre-edge values.
            x_q      <= x_d;
            y_q      <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            status_q <= status_d;
        end
    end

    assign ball_x     = x_q;
    assign ball_y     = y_q;
    assign ballStatus = status_q;

endmodule

// File: tb/tb_ball_engine.sv
// -----------------------------------------------------------------------------
// tb_ball_engine
//
// Two instances share clock, reset, state and serve:
//   dut0 - default 640x480 playfield
//   dut1 - 640x106 playfield, sized so that the ball meets the left paddle
//          and the top wall on the same tick (corner case)
// A frame-level model predicts both balls; a compare process checks every
// cycle, and directed literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_ball_engine;

    localparam int TD         = 4;
    localparam int SW         = 640;
    localparam int BS         = 8;
    localparam int PW         = 8;
    localparam int PH         = 64;
    localparam int P1_X       = 16;
    localparam int P2_X       = 616;
    localparam int SPEED_INIT = 2;
    localparam int SPEED_MAX  = 6;
    localparam int H0         = 480;
    localparam int H1         = 106;

`ifdef BALL_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic [1:0] state = 2'b00;
    logic       serve = 1'b0;

    logic [9:0] p1_0 = '0, p2_0 = '0, p1_1 = '0, p2_1 = '0;
    logic [9:0] x0, y0, x1, y1;
    logic [1:0] s0, s1;

    int  n_checks = 0;
    int  n_errors = 0;
    bit  chk_en   = 1'b0;
    bit  trk1 [2];
    bit  trk2 [2];

    // Frame-level model
    int  hgt [2] = '{H0, H1};
    int  mx [2], my [2], ms [2], mdx [2], mdy [2], mspd [2];
    int  mcnt;

    ball_engine #(.TICK_DIV(TD)) dut0 (
        .clk(clk), .rst(rst), .state(state), .serve(serve),
        .paddle1_y(p1_0), .paddle2_y(p2_0),
        .ball_x(x0), .ball_y(y0), .ballStatus(s0)
    );

    ball_engine #(.SCREEN_H(H1), .TICK_DIV(TD)) dut1 (
        .clk(clk), .rst(rst), .state(state), .serve(serve),
        .paddle1_y(p1_1), .paddle2_y(p2_1),
        .ball_x(x1), .ball_y(y1), .ballStatus(s1)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    task automatic model_reset();
        mcnt = 0;
        for (int i = 0; i < 2; i++) begin
            mx[i] = (SW - BS) / 2;  my[i] = (hgt[i] - BS) / 2;
            ms[i] = 0;  mdx[i] = 1;  mdy[i] = 1;  mspd[i] = SPEED_INIT;
        end
    endtask

    task automatic model_ball(input int i, input bit tk, input int pa, input int pb);
        int  nx, ny;
        bit  hl, hr;
        if (state != 2'd2) begin
            mx[i] = (SW - BS) / 2;  my[i] = (hgt[i] - BS) / 2;
            ms[i] = 0;  mdx[i] = serve ? 0 : 1;  mdy[i] = 1;  mspd[i] = SPEED_INIT;
        end else if (ms[i] == 0 && tk) begin
            nx = (mdx[i] == 1) ? mx[i] + mspd[i] : mx[i] - mspd[i];
            ny = (mdy[i] == 1) ? my[i] + 1 : my[i] - 1;
            hl = (mdx[i] == 0) && (nx < P1_X + PW) && (nx + BS > P1_X)
                 && (my[i] + BS > pa) && (my[i] < pa + PH);
            hr = (mdx[i] == 1) && (nx < P2_X + PW) && (nx + BS > P2_X)
                 && (my[i] + BS > pb) && (my[i] < pb + PH);
            if (ny <= 0)                begin my[i] = 0;               mdy[i] = 1; end
            else if (ny >= hgt[i] - BS) begin my[i] = hgt[i] - BS;     mdy[i] = 0; end
            else                              my[i] = ny;
            if (hl || hr) begin
                mx[i]  = hl ? P1_X + PW : P2_X - BS;
                mdx[i] = hl ? 1 : 0;
                if (SPEEDUP && mspd[i] < SPEED_MAX) mspd[i]++;
            end else if (nx <= 0) begin
                mx[i] = 0;        ms[i] = 2;
            end else if (nx >= SW - BS) begin
                mx[i] = SW - BS;  ms[i] = 1;
            end else begin
                mx[i] = nx;
            end
        end
    endtask

    task automatic model_clock();
        bit tk;
        tk   = (mcnt == TD - 1);
        mcnt = tk ? 0 : mcnt + 1;
        model_ball(0, tk, int'(p1_0), int'(p2_0));
        model_ball(1, tk, int'(p1_1), int'(p2_1));
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else      model_clock();
    end

    // ---------------- paddles ----------------
    function automatic logic [9:0] follow(input int y);
        return (y >= 28) ? 10'(y - 28) : 10'd0;
    endfunction

    task automatic drive_paddles();
        #1;
        p1_0 = trk1[0] ? follow(my[0]) : 10'd0;
        p2_0 = trk2[0] ? follow(my[0]) : 10'd0;
        p1_1 = trk1[1] ? follow(my[1]) : 10'd0;
        p2_1 = trk2[1] ? follow(my[1]) : 10'd0;
    endtask

    always @(negedge clk) drive_paddles();

    // ---------------- per-cycle compare ----------------
    task automatic compare_all();
        if (chk_en) begin
            check("ball_x[0]", int'(x0), mx[0]);
            check("ball_y[0]", int'(y0), my[0]);
            check("status[0]", int'(s0), ms[0]);
            check("ball_x[1]", int'(x1), mx[1]);
            check("ball_y[1]", int'(y1), my[1]);
            check("status[1]", int'(s1), ms[1]);
        end
    endtask

    always @(negedge clk) compare_all();

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int prev;
        trk1 = '{1'b0, 1'b1};   // dut0 left paddle parked at the top
        trk2 = '{1'b1, 1'b1};

        // Reset values
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_x0", int'(x0), 316);
        check("rst_y0", int'(y0), 236);
        check("rst_s0", int'(s0), 0);
        check("rst_y1", int'(y1), 49);

        // Serve from player 2, then PLAY: first move on first tick only
        #1 rst = 1'b1; state = 2'd1; serve = 1'b1;
        repeat (2) @(negedge clk);
        #1 state = 2'd2;
        n = 0;
        do begin @(negedge clk); n++; end while (x0 == 10'd316 && n < 2 * TD);
        check("first_tick_seen", (n < 2 * TD) ? 1 : 0, 1);
        check("first_x0", int'(x0), 314);
        check("first_y0", int'(y0), 237);
        for (int c = 0; c < TD - 1; c++) begin
            @(negedge clk);
            check("no_tick_hold_x0", int'(x0), 314);
        end
        @(negedge clk);
        check("second_x0", int'(x0), 312);
        check("second_y0", int'(y0), 238);

        // Tick 146: dut1 at (24,1) heading up-left into paddle and top wall
        n = 0;
        do begin @(negedge clk); n++; end while (!(x1 == 10'd24 && y1 == 10'd1) && n < 1000);
        check("corner_reached", (n < 1000) ? 1 : 0, 1);
        check("t146_x0", int'(x0), 24);
        check("t146_y0", int'(y0), 382);
        prev = int'(y1);
        n = 0;
        do begin @(negedge clk); n++; end while (int'(y1) == prev && n < 2 * TD);
        check("corner_x1", int'(x1), 24);
        check("corner_y1", int'(y1), 0);
        check("corner_s1", int'(s1), 0);
        check("pass_paddle_x0", int'(x0), 22);
        prev = int'(y1);
        n = 0;
        do begin @(negedge clk); n++; end while (int'(y1) == prev && n < 2 * TD);
        check("after_corner_x1", int'(x1), SPEEDUP ? 27 : 26);
        check("after_corner_y1", int'(y1), 1);

        // Left miss on dut0: status latched and ball frozen
        n = 0;
        do begin @(negedge clk); n++; end while (s0 != 2'd2 && n < 200);
        check("miss_seen", (n < 200) ? 1 : 0, 1);
        check("miss_x0", int'(x0), 0);
        check("miss_y0", int'(y0), 394);
        repeat (2 * TD + 1) @(negedge clk);
        check("miss_hold_s0", int'(s0), 2);
        check("miss_hold_x0", int'(x0), 0);
        check("miss_hold_y0", int'(y0), 394);
        #1 state = 2'd1;
        @(negedge clk);
        check("serve_s0", int'(s0), 0);
        check("serve_x0", int'(x0), 316);
        check("serve_y0", int'(y0), 236);

        // Player 1 serves; right paddle hit on dut0
        #1 serve = 1'b0; trk1[0] = 1'b1;
        repeat (2) @(negedge clk);
        #1 state = 2'd2;
        n = 0;
        do begin @(negedge clk); n++; end while (x0 != 10'd608 && n < 1000);
        check("right_reach", (n < 1000) ? 1 : 0, 1);
        check("right_reach_y0", int'(y0), 382);
        prev = int'(y0);
        n = 0;
        do begin @(negedge clk); n++; end while (int'(y0) == prev && n < 2 * TD);
        check("right_hit_x0", int'(x0), 608);
        check("right_hit_y0", int'(y0), 383);
        prev = int'(y0);
        n = 0;
        do begin @(negedge clk); n++; end while (int'(y0) == prev && n < 2 * TD);
        check("rebound_x0", int'(x0), SPEEDUP ? 605 : 606);
        check("rebound_y0", int'(y0), 384);

        // Long rally: walls, repeated hits, speed saturation (model-checked)
        repeat (4000) @(negedge clk);

        // DONE parks the ball
        #1 state = 2'd3;
        @(negedge clk);
        check("done_x0", int'(x0), 316);
        check("done_y0", int'(y0), 236);
        check("done_s0", int'(s0), 0);
        #1 state = 2'd2;
        repeat (50) @(negedge clk);

        // Asynchronous reset mid-PLAY, then the counter restarts from 0
        #3 rst = 1'b0;
        @(negedge clk);
        check("midrst_x0", int'(x0), 316);
        check("midrst_y0", int'(y0), 236);
        check("midrst_s0", int'(s0), 0);
        check("midrst_y1", int'(y1), 49);
        #1 rst = 1'b1;
        repeat (TD - 1) @(negedge clk);
        check("restart_hold_x0", int'(x0), 316);
        @(negedge clk);
        check("restart_x0", int'(x0), 318);
        check("restart_y0", int'(y0), 237);
        check("restart_y1", int'(y1), 50);

        repeat (20) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
